// File: rtl/dmem_ls_ctrl.sv
// Load/store sequencer for the single-port, word-wide data RAM behind MEM/WB.
// One request in flight at a time. Sub-word stores are read-modify-write
// because the RAM has no byte enables.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | ready for a request
// ERR      | illegal funct3 or misaligned; error response
// LD_RD    | load: RAM read issued
// LD_WAIT  | load: read data returned, formatted
// LD_RSP   | load: response cycle
// ST_WR    | SW: RAM write issued
// RMW_RD   | SB/SH: read of the target word issued
// RMW_WAIT | SB/SH: read data returned, lane merged
// RMW_WR   | SB/SH: merged word written
// ST_RSP   | store: response cycle
module dmem_ls_ctrl #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [31:0]       req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              resp_valid_o,
  output logic [31:0]       resp_data_o,
  output logic              resp_err_o,
  output logic              busy_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i
);

  typedef enum logic [3:0] {
    IDLE, ERR, LD_RD, LD_WAIT, LD_RSP, ST_WR, RMW_RD, RMW_WAIT, RMW_WR, ST_RSP
  } state_t;

  state_t      state;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;

  // Byte address bits above the RAM wrap around and are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr_i[31:ADDR_W+2];

  function automatic logic legal(input logic we, input logic [2:0] f3, input logic [1:0] lo);
    logic ok;
    ok = 1'b0;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = !lo[0];
      3'b010:  ok = (lo == 2'b00);
      3'b100,
      3'b101:  ok = !we && !lo[0] || !we && !f3[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h0, b};
      3'b101:  r = {16'h0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic half, input logic [1:0] lo,
                                        input logic [31:0] w, input logic [31:0] wd);
    logic [31:0] r;
    r = w;
    if (half) begin
      if (lo[1]) r[31:16] = wd[15:0];
      else       r[15:0]  = wd[15:0];
    end else begin
      case (lo)
        2'd0:    r[7:0]   = wd[7:0];
        2'd1:    r[15:8]  = wd[7:0];
        2'd2:    r[23:16] = wd[7:0];
        default: r[31:24] = wd[7:0];
      endcase
    end
    return r;
  endfunction

  assign req_ready_o = (state == IDLE) && !rst;
  assign busy_o      = (state != IDLE);

  // Sequencer: state, latched request and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      funct3_q     <= 3'b0;
      lane_q       <= 2'b0;
      wdata_q      <= 32'h0;
      resp_valid_o <= 1'b0;
      resp_err_o   <= 1'b0;
      resp_data_o  <= 32'h0;
      ram_en_o     <= 1'b0;
      ram_we_o     <= 1'b0;
      ram_addr_o   <= '0;
      ram_wdata_o  <= 32'h0;
    end else begin
      resp_valid_o <= 1'b0;
      resp_err_o   <= 1'b0;
      resp_data_o  <= 32'h0;
      ram_en_o     <= 1'b0;
      ram_we_o     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid_i) begin
            funct3_q   <= req_funct3_i;
            lane_q     <= req_addr_i[1:0];
            wdata_q    <= req_wdata_i;
            ram_addr_o <= req_addr_i[ADDR_W+1:2];
            if (!legal(req_we_i, req_funct3_i, req_addr_i[1:0])) begin
              state        <= ERR;
              resp_valid_o <= 1'b1;
              resp_err_o   <= 1'b1;
            end else if (req_we_i && req_funct3_i == 3'b010) begin
              state       <= ST_WR;
              ram_en_o    <= 1'b1;
              ram_we_o    <= 1'b1;
              ram_wdata_o <= req_wdata_i;
            end else if (req_we_i) begin
              state    <= RMW_RD;
              ram_en_o <= 1'b1;
            end else begin
              state    <= LD_RD;
              ram_en_o <= 1'b1;
            end
          end
        end
        LD_RD:   state <= LD_WAIT;
        LD_WAIT: begin
          state        <= LD_RSP;
          resp_valid_o <= 1'b1;
          resp_data_o  <= fmt_load(funct3_q, lane_q, ram_rdata_i);
        end
        ST_WR: begin
          state        <= ST_RSP;
          resp_valid_o <= 1'b1;
        end
        RMW_RD:  state <= RMW_WAIT;
        RMW_WAIT: begin
          state       <= RMW_WR;
          ram_en_o    <= 1'b1;
          ram_we_o    <= 1'b1;
          ram_wdata_o <= merge(funct3_q[0], lane_q, ram_rdata_i, wdata_q);
        end
        RMW_WR: begin
          state        <= ST_RSP;
          resp_valid_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ls_ctrl.sv
// Directed bench for dmem_ls_ctrl with a behavioural 1-cycle-read RAM.
module tb_dmem_ls_ctrl;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready_o;
  logic              req_we = 1'b0;
  logic [2:0]        req_funct3 = 3'b0;
  logic [31:0]       req_addr = 32'h0;
  logic [31:0]       req_wdata = 32'h0;
  logic              resp_valid_o;
  logic [31:0]       resp_data_o;
  logic              resp_err_o;
  logic              busy_o;
  logic              ram_en_o;
  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [31:0]       ram_wdata_o;
  logic [31:0]       ram_rdata = 32'h0;

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [31:0]       pl_data = 32'h0;

  int checks = 0;
  int failures = 0;

  int          r_we_k, r_we_cnt, r_rd_cnt, r_en_cnt;
  logic [31:0] r_we_data;

  always #5 clk = ~clk;

  dmem_ls_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_we_i(req_we),
    .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
    .busy_o(busy_o), .ram_en_o(ram_en_o), .ram_we_o(ram_we_o),
    .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata)
  );

  // RAM model: registered read, write on enable, plus a backdoor preload port.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_en_o) begin
      if (ram_we_o) mem[ram_addr_o] <= ram_wdata_o;
      else          ram_rdata <= mem[ram_addr_o];
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1 pl_en = 1'b0;
    @(negedge clk);
  endtask

  // Issues one request (entered and left at a negedge) and checks latency,
  // response data/error, continuous busy, and a single response pulse.
  task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input bit hold,
                         input int exp_lat, input logic [31:0] exp_data, input logic exp_err);
    int          n, lat, busy_bad;
    logic [31:0] d;
    logic        e;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready_o && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    lat = 0; d = 32'h0; e = 1'b0; busy_bad = 0;
    r_we_k = 0; r_we_cnt = 0; r_rd_cnt = 0; r_en_cnt = 0; r_we_data = 32'h0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (!busy_o) busy_bad++;
      if (ram_en_o) r_en_cnt++;
      if (ram_en_o && !ram_we_o) r_rd_cnt++;
      if (ram_en_o && ram_we_o) begin r_we_cnt++; r_we_k = k; r_we_data = ram_wdata_o; end
      if (resp_valid_o) begin lat = k; d = resp_data_o; e = resp_err_o; break; end
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_data"}, d, exp_data);
    check({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
    check({tag, "_busy"}, busy_bad, 0);
    @(negedge clk);
    check({tag, "_idle_after"}, {30'b0, resp_valid_o, req_ready_o}, 32'h1);
  endtask

  initial begin
    int we_after, rv_after;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, req_ready_o}, 0);
    check("rst_outs", {26'b0, busy_o, resp_valid_o, resp_err_o, ram_en_o, ram_we_o,
                       |resp_data_o}, 0);
    check("rst_addr", {20'b0, ram_addr_o}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'b0, req_ready_o}, 1);

    // Loads with sign/zero extension
    preload(12'h4, 32'h80FF7F01);
    run_req("lb", 1'b0, 3'b000, 32'h12, 32'h0, 1'b0, 3, 32'hFFFFFFFF, 1'b0);
    check("lb_reads", r_rd_cnt, 1);
    run_req("lbu", 1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 3, 32'h00000080, 1'b0);
    run_req("lh", 1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 3, 32'hFFFF80FF, 1'b0);
    run_req("lhu", 1'b0, 3'b101, 32'h10, 32'h0, 1'b0, 3, 32'h00007F01, 1'b0);
    run_req("lb_pos", 1'b0, 3'b000, 32'h10, 32'h0, 1'b0, 3, 32'h00000001, 1'b0);
    run_req("lw_wrap", 1'b0, 3'b010, 32'h4010, 32'h0, 1'b0, 3, 32'h80FF7F01, 1'b0);

    // Sub-word stores via read-modify-write
    preload(12'h4, 32'h11223344);
    run_req("sb", 1'b1, 3'b000, 32'h11, 32'hAABBCCDD, 1'b0, 4, 32'h0, 1'b0);
    check("sb_we_cycle", r_we_k, 3);
    check("sb_we_data", r_we_data, 32'h1122DD44);
    check("sb_mem", mem[4], 32'h1122DD44);
    preload(12'h4, 32'h11223344);
    run_req("sh", 1'b1, 3'b001, 32'h12, 32'h0000BEEF, 1'b0, 4, 32'h0, 1'b0);
    check("sh_we_data", r_we_data, 32'hBEEF3344);
    check("sh_mem", mem[4], 32'hBEEF3344);

    // Full-word store then readback
    run_req("sw", 1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 1'b0, 2, 32'h0, 1'b0);
    check("sw_we_cycle", r_we_k, 1);
    check("sw_we_cnt", r_we_cnt, 1);
    check("sw_reads", r_rd_cnt, 0);
    check("sw_mem", mem[8], 32'hDEADBEEF);
    run_req("lw", 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 3, 32'hDEADBEEF, 1'b0);

    // Illegal requests: no RAM access
    run_req("err_lw", 1'b0, 3'b010, 32'h22, 32'h0, 1'b0, 1, 32'h0, 1'b1);
    check("err_lw_en", r_en_cnt, 0);
    run_req("err_sh", 1'b1, 3'b001, 32'h13, 32'h1234, 1'b0, 1, 32'h0, 1'b1);
    check("err_sh_en", r_en_cnt, 0);
    run_req("err_f3", 1'b0, 3'b011, 32'h20, 32'h0, 1'b0, 1, 32'h0, 1'b1);
    check("err_f3_en", r_en_cnt, 0);
    run_req("err_sbu", 1'b1, 3'b100, 32'h20, 32'h0, 1'b0, 1, 32'h0, 1'b1);

    // Reset in the middle of an RMW
    preload(12'h4, 32'h11223344);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10;
    req_wdata = 32'hAABBCCDD;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    we_after = 0; rv_after = 0;
    @(negedge clk);
    if (ram_we_o) we_after++;
    if (resp_valid_o) rv_after++;
    rst = 1'b0;
    @(negedge clk);
    check("rmw_rst_ready", {31'b0, req_ready_o}, 1);
    for (int i = 0; i < 5; i++) begin
      if (ram_we_o) we_after++;
      if (resp_valid_o) rv_after++;
      @(negedge clk);
    end
    check("rmw_rst_we", we_after, 0);
    check("rmw_rst_resp", rv_after, 0);
    check("rmw_rst_mem", mem[4], 32'h11223344);

    // Back-to-back queue with req_valid held high throughout
    run_req("q_lw", 1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 3, 32'hDEADBEEF, 1'b0);
    run_req("q_sb", 1'b1, 3'b000, 32'h13, 32'h000000A5, 1'b1, 4, 32'h0, 1'b0);
    run_req("q_lbu", 1'b0, 3'b100, 32'h13, 32'h0, 1'b1, 3, 32'h000000A5, 1'b0);
    run_req("q_err", 1'b0, 3'b001, 32'h11, 32'h0, 1'b1, 1, 32'h0, 1'b1);
    req_valid = 1'b0;
    check("q_mem", mem[4], 32'hA5223344);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
